// File: rtl/uart_rx_fsm.sv
`timescale 1ns/1ps
// uart_rx_fsm: 8-bit asynchronous serial receiver (start, 8 data LSB first,
// optional even parity, 1 stop). Optional parity is compiled in with the
// macro UART_RX_PARITY_EN; without it the frame is 10 bits and parity_err is 0.
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    // High when data plus parity bit do not XOR to zero (even parity broken).
    function automatic logic even_parity_bad(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction
`endif

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic        rx_d_q;
    logic        rx_s;
    logic        rx_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dataout_q, dataout_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;
    logic        parity_bad_s;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        parity_err_q, parity_err_d;
`endif

    assign rx_s = sync_q[1];
    assign rx_d = rx_d_q;

`ifdef UART_RX_PARITY_EN
    assign parity_bad_s = even_parity_bad(shift_q, par_q);
`else
    assign parity_bad_s = 1'b0;
`endif

    // Next-state, bit timing and output pulse generation.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        dataout_d    = dataout_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                timer_d   = 16'd0;
                bit_cnt_d = 3'd0;
                // Only a genuine high-to-low edge starts a frame; a line that
                // stays low (e.g. after a framing error) never retriggers.
                if (rx_d && !rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_q == HALF_BIT) begin
                    timer_d = 16'd0;
                    // Still low at mid start bit: real start, otherwise a glitch.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d   = 16'd0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = 16'd0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = 16'd0;
                    state_d = ST_IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else if (parity_bad_s) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_d = 1'b1;
`else
                        frame_err_d = 1'b0;
`endif
                    end else begin
                        valid_d   = 1'b1;
                        dataout_d = shift_q;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                timer_d   = 16'd0;
                bit_cnt_d = 3'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Synchronizer, edge-detect history, FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= 2'b11;
            rx_d_q       <= 1'b1;
            state_q      <= ST_IDLE;
            timer_q      <= 16'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            dataout_q    <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[0], rx};
            rx_d_q       <= sync_q[1];
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            dataout_q    <= dataout_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dataout   = dataout_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_fsm at CLKS_PER_BIT=16: table of single
// frames plus hand-written sequences for glitch, held-low line, back-to-back
// frames, mid-frame reset and (when compiled in) parity.
module tb_uart_rx_fsm;

    localparam int CPB    = 16;
    localparam int PERIOD = 10;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_LAT = CPB / 2 + 10 * CPB + 2;
`else
    localparam int EXP_LAT = CPB / 2 + 9 * CPB + 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] dataout;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   ferr_cnt = 0;
    int   perr_cnt = 0;
    int   busy_cycles = 0;
    time  last_valid_t = 0;
    time  t_fall = 0;
    logic [7:0] rx_bytes[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_v;
        int         exp_f;
        logic [7:0] exp_dout;
    } vec_t;
    vec_t vecs[6];

    uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .dataout(dataout), .valid(valid),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #(PERIOD / 2) clk = ~clk;

    // Count output pulses and busy cycles, sampled away from the rising edge.
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt    <= valid_cnt + 1;
            last_valid_t <= $time;
            rx_bytes.push_back(dataout);
        end
        if (frame_err)  ferr_cnt    <= ferr_cnt + 1;
        if (parity_err) perr_cnt    <= perr_cnt + 1;
        if (busy)       busy_cycles <= busy_cycles + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Full frame; par_inv flips the (even) parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_inv);
        t_fall = $time;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_inv);
`endif
        send_bit(stop);
    endtask

    initial begin
        int v0, f0, p0, b0, lat;
        vecs[0] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[1] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vecs[2] = '{8'hFF, 1'b0, 0, 1, 8'h5A};
        vecs[3] = '{8'hC3, 1'b1, 1, 0, 8'hC3};
        vecs[4] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[5] = '{8'h80, 1'b0, 0, 1, 8'h01};

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dataout", dataout, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        idle(5);

        // Short low glitch: start rejected at mid start bit, no pulses.
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt; b0 = busy_cycles;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        check("glitch_pulses", (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        check("glitch_busy_seen", int'((busy_cycles - b0) > 0), 1);
        check("glitch_busy_max", int'((busy_cycles - b0) <= 10), 1);
        check("glitch_idle", busy, 0);

        // 0xA5 with good stop, including latency from the falling edge.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        check("a5_valid", valid_cnt - v0, 1);
        check("a5_frame_err", ferr_cnt - f0, 0);
        check("a5_dataout", dataout, 8'hA5);
        check("a5_busy", busy, 0);
        // Fall is driven half a cycle before the first edge that sees it and
        // valid is seen half a cycle after its edge: one cycle of offset.
        lat = int'((last_valid_t - t_fall) / PERIOD) - 1;
        check("a5_latency_ok", int'(lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1);

        // Table of single frames separated by idle line.
        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            idle(20);
            check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_v);
            check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, vecs[i].exp_f);
            check($sformatf("vec%0d_parity_err", i), perr_cnt - p0, 0);
            check($sformatf("vec%0d_dataout", i), dataout, vecs[i].exp_dout);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end

        // 0x3C with bad stop then line held low: one frame_err, no retrigger.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        b0 = busy_cycles;
        repeat (100) @(negedge clk);
        check("low_frame_err", ferr_cnt - f0, 1);
        check("low_no_valid", valid_cnt - v0, 0);
        check("low_dataout", dataout, 8'h01);
        check("low_busy_cycles", busy_cycles - b0, 0);
        idle(10);
        send_frame(8'h6E, 1'b1, 1'b0);
        idle(20);
        check("after_low_valid", valid_cnt - v0, 1);
        check("after_low_dataout", dataout, 8'h6E);

        // Back-to-back frames with no idle between stop and next start.
        v0 = valid_cnt;
        rx_bytes.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check("b2b_count", valid_cnt - v0, 3);
        check("b2b_queue_len", rx_bytes.size(), 3);
        if (rx_bytes.size() == 3) begin
            check("b2b_byte0", rx_bytes[0], 8'h00);
            check("b2b_byte1", rx_bytes[1], 8'hFF);
            check("b2b_byte2", rx_bytes[2], 8'h81);
        end else begin
            check("b2b_bytes_present", 0, 1);
        end

        // Reset in the middle of D3 of 0x55, then a clean 0x12.
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) send_bit(i % 2 == 0);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rx    = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_dataout", dataout, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        reset = 1'b0;
        idle(40);
        check("midrst_pulses", (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        check("midrst_idle", busy, 0);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(20);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_dataout", dataout, 8'h12);

`ifdef UART_RX_PARITY_EN
        // 0x07: wrong parity bit then correct one.
        v0 = valid_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        check("par_bad_perr", perr_cnt - p0, 1);
        check("par_bad_valid", valid_cnt - v0, 0);
        check("par_bad_dataout", dataout, 8'h12);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        check("par_ok_valid", valid_cnt - v0, 1);
        check("par_ok_perr", perr_cnt - p0, 1);
        check("par_ok_dataout", dataout, 8'h07);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 5208, clk cycles per serial bit period (legal range 4..65535).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  serial line, idle high; asynchronous to clk.
REQ-005 dataout  output  8  last correctly received byte.
REQ-006 valid  output  1  one-cycle pulse; dataout updated in the same cycle.
REQ-007 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 parity_err  output  1  one-cycle pulse; parity mismatch (see Configuration).
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value (rx_s) and its one-cycle-delayed copy (rx_d).
REQ-011 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP; the encoding is implementer's choice.
REQ-013 IDLE -> START SHALL occur only on a falling edge (rx_d=1, rx_s=0); a line held low SHALL NOT retrigger reception.
REQ-014 START: a 16-bit bit-timer SHALL count to CLKS_PER_BIT/2 (integer division); if rx_s=0 at that point -> DATA with timer cleared, else -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: rx_s SHALL be sampled each time the timer reaches CLKS_PER_BIT-1 (mid-bit); bit k SHALL be shifted into position k; after the 8th sample -> PARITY if enabled, else STOP.
REQ-016 PARITY: one mid-bit sample SHALL be stored, then -> STOP.
REQ-017 STOP: at the mid-bit sample the FSM SHALL return to IDLE on the next edge and, in the same cycle, assert exactly one of: valid (stop=1, parity ok), frame_err (stop=0), parity_err (stop=1, parity bad).
REQ-018 dataout SHALL update only with valid; on frame_err or parity_err it SHALL hold its previous value.
REQ-019 Latency: valid SHALL assert CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+CLKS_PER_BIT with parity) +2 (synchronizer) cycles after the rx falling edge, +/-1 cycle.
REQ-020 A falling edge on rx during a non-IDLE state SHALL be ignored; back-to-back frames with zero idle time between the stop and the next start bit SHALL be received without loss.
REQ-021 The bit-timer SHALL clear on every state transition and SHALL never wrap within a state.

Reset
REQ-022 While reset=1: state=IDLE, timer=0, bit counter=0, shift register=0, dataout=8'h00, valid=0, frame_err=0, parity_err=0, busy=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no output pulse; after release, reception SHALL resume only on a new falling edge.

Configuration
REQ-024 Macro UART_RX_PARITY_EN: when defined, the PARITY state SHALL be present and an even-parity bit (XOR of D0..D7 and the parity bit = 0) SHALL be checked; the frame is 11 bits.
REQ-025 When UART_RX_PARITY_EN is undefined, the PARITY state SHALL be absent, the frame is 10 bits, and parity_err SHALL be tied to 0.

Verification (CLKS_PER_BIT=16)
REQ-026 Send 0xA5, correct stop -> one valid pulse, dataout=0xA5, frame_err=0, busy low again after the stop sample.
REQ-027 rx low pulse of 4 clk, then high -> no pulse on any output, FSM back in IDLE, busy high for no more than 10 cycles.
REQ-028 Send 0x3C with stop bit=0, rx then held low for 100 clk -> one frame_err pulse, dataout unchanged, no new reception until rx goes high and falls again.
REQ-029 Send 0x00, 0xFF, 0x81 back-to-back with zero idle time -> three valid pulses, dataout=0x00, 0xFF, 0x81 in order.
REQ-030 reset pulsed in the middle of bit D3 of 0x55 -> all outputs at reset values, no pulse; next frame 0x12 -> valid, dataout=0x12.
REQ-031 With UART_RX_PARITY_EN defined: send 0x07 with parity bit=0 -> one parity_err pulse, no valid; send 0x07 with parity bit=1 -> valid, dataout=0x07.
